// File: rtl/lane_reorder_ctrl_pkg.sv
// Shared definitions for the RX lane-reorder controller and the lane-swap datapath.
package lane_reorder_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_BUILD   = 3'd1,
        ST_DONE    = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    localparam int N_LANES_DEF = 20;

    // Width of one lane ID; never collapses to zero bits for a single lane.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // MSB position of field k in a packed bus; field 0 sits at the top of the bus.
    function automatic int field_msb(input int nb_bus, input int nb_id, input int k);
        return nb_bus - 1 - k * nb_id;
    endfunction

endpackage

// File: rtl/lane_reorder_ctrl.sv
// Lane-reorder controller: gathers per-phy-lane logical IDs once all lanes hold AM lock,
// validates them as a permutation, builds the logical->phy selector bus and then paces
// the serialiser with a done strobe followed by shift/load pulses.
module lane_reorder_ctrl
    import lane_reorder_ctrl_pkg::*;
#(
    parameter int N_LANES   = N_LANES_DEF,
    parameter int NB_ID     = id_width(N_LANES),
    parameter int NB_ID_BUS = NB_ID * N_LANES
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic                 i_restart,
    input  logic [N_LANES-1:0]   i_am_lock,
    input  logic [NB_ID_BUS-1:0] i_lane_ids,
    output logic [NB_ID_BUS-1:0] o_sel_ids,
    output logic                 o_reorder_done,
    output logic                 o_load,
    output logic                 o_shift_enable,
    output logic                 o_aligned,
    output logic                 o_error,
    output logic [NB_ID-1:0]     o_err_lane
);

    state_t                 r_state;
    state_t                 w_next;
    logic [NB_ID_BUS-1:0]   r_snap;
    logic [NB_ID_BUS-1:0]   r_sel;
    logic [N_LANES-1:0]     r_seen;
    logic [NB_ID-1:0]       r_idx;
    logic [NB_ID-1:0]       r_cnt;
    logic [NB_ID-1:0]       r_err_lane;
    logic                   r_done;
    logic                   r_load;
    logic                   r_shift;

    logic                   w_all_lock;
    logic [NB_ID-1:0]       w_id;
    logic                   w_id_bad;
    logic                   w_seen_hit;
    logic                   w_idx_last;
    logic                   w_cnt_last;
    logic                   w_run_tick;

    assign w_all_lock = &i_am_lock;
    assign w_idx_last = (r_idx == NB_ID'(N_LANES - 1));
    assign w_cnt_last = (r_cnt == NB_ID'(N_LANES - 1));

    // Pick the snapshotted ID of the phy lane under test and check it against range and the seen bitmap.
    always_comb begin
        w_id       = '0;
        w_seen_hit = 1'b0;
        for (int k = 0; k < N_LANES; k++) begin
            if (r_idx == NB_ID'(k)) w_id = r_snap[field_msb(NB_ID_BUS, NB_ID, k) -: NB_ID];
        end
        for (int k = 0; k < N_LANES; k++) begin
            if (w_id == NB_ID'(k) && r_seen[k]) w_seen_hit = 1'b1;
        end
        w_id_bad = (int'(w_id) >= N_LANES) || w_seen_hit;
    end

    // Next-state: restart beats lock-loss beats normal progress.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_COLLECT: if (w_all_lock) w_next = ST_BUILD;
            ST_BUILD: begin
                if (w_id_bad)        w_next = ST_ERROR;
                else if (w_idx_last) w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_RUN;
            ST_RUN:   w_next = ST_RUN;
            ST_ERROR: w_next = ST_ERROR;
            default:  w_next = ST_COLLECT;
        endcase
        if (r_state != ST_COLLECT && !w_all_lock) w_next = ST_COLLECT;
        if (i_restart)                            w_next = ST_COLLECT;
    end

    // A RUN pacing step only counts if RUN is not being abandoned on this edge.
    assign w_run_tick = (r_state == ST_RUN) && i_enable && (w_next == ST_RUN);

    // State register, registered strobes and the BUILD/RUN datapath registers.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state    <= ST_COLLECT;
            r_snap     <= '0;
            r_sel      <= '0;
            r_seen     <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_err_lane <= '0;
            r_done     <= 1'b0;
            r_load     <= 1'b0;
            r_shift    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == ST_DONE);
            r_load  <= w_run_tick && w_cnt_last;
            r_shift <= w_run_tick && !w_cnt_last;
            case (r_state)
                ST_COLLECT: begin
                    if (w_next == ST_BUILD) begin
                        r_snap <= i_lane_ids;
                        r_seen <= '0;
                        r_idx  <= '0;
                    end
                end
                ST_BUILD: begin
                    if (w_next == ST_ERROR) begin
                        r_err_lane <= r_idx;
                    end else if (w_next != ST_COLLECT) begin
                        for (int k = 0; k < N_LANES; k++) begin
                            if (w_id == NB_ID'(k)) begin
                                r_sel[field_msb(NB_ID_BUS, NB_ID, k) -: NB_ID] <= r_idx;
                                r_seen[k] <= 1'b1;
                            end
                        end
                        if (!w_idx_last) r_idx <= r_idx + NB_ID'(1);
                    end
                end
                ST_DONE: r_cnt <= '0;
                ST_RUN: begin
                    if (w_run_tick) r_cnt <= w_cnt_last ? '0 : r_cnt + NB_ID'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_sel_ids      = r_sel;
    assign o_reorder_done = r_done;
    assign o_load         = r_load;
    assign o_shift_enable = r_shift;
    assign o_aligned      = (r_state == ST_RUN);
    assign o_error        = (r_state == ST_ERROR);
    assign o_err_lane     = r_err_lane;

endmodule

// File: tb/tb_lane_reorder_ctrl.sv
// Bench for lane_reorder_ctrl: a 4-lane instance for the directed scenarios and a default
// 20-lane instance for large random permutations, both checked against a permutation model.
module tb_lane_reorder_ctrl;
    localparam int NA = 4;
    localparam int WA = 2;
    localparam int NB = 20;
    localparam int WB = 5;

    typedef int ids_t [NB];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic              a_en, a_rs, a_done, a_load, a_shift, a_al, a_er;
    logic [NA-1:0]     a_lock;
    logic [NA*WA-1:0]  a_ids, a_sel;
    logic [WA-1:0]     a_el;

    logic              b_en, b_rs, b_done, b_load, b_shift, b_al, b_er;
    logic [NB-1:0]     b_lock;
    logic [NB*WB-1:0]  b_ids, b_sel;
    logic [WB-1:0]     b_el;

    int vectors = 0;
    int miscompares = 0;

    lane_reorder_ctrl #(.N_LANES(NA)) u_dut_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_enable(a_en), .i_restart(a_rs),
        .i_am_lock(a_lock), .i_lane_ids(a_ids), .o_sel_ids(a_sel),
        .o_reorder_done(a_done), .o_load(a_load), .o_shift_enable(a_shift),
        .o_aligned(a_al), .o_error(a_er), .o_err_lane(a_el)
    );

    lane_reorder_ctrl u_dut_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_enable(b_en), .i_restart(b_rs),
        .i_am_lock(b_lock), .i_lane_ids(b_ids), .o_sel_ids(b_sel),
        .o_reorder_done(b_done), .o_load(b_load), .o_shift_enable(b_shift),
        .o_aligned(b_al), .o_error(b_er), .o_err_lane(b_el)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Field p of an n-lane bus holds v[p]; field 0 is at the MSB end.
    function automatic logic [NB*WB-1:0] pack_bus(input ids_t v, input int n, input int w);
        logic [NB*WB-1:0] r;
        r = '0;
        for (int p = 0; p < n; p++)
            for (int b = 0; b < w; b++) r[n*w - (p+1)*w + b] = v[p][b];
        return r;
    endfunction

    // Selector for logical lane L is the phy lane that carried L.
    function automatic logic [NB*WB-1:0] exp_sel(input ids_t id, input int n, input int w);
        ids_t s;
        s = '{default: 0};
        for (int p = 0; p < n; p++) s[id[p]] = p;
        return pack_bus(s, n, w);
    endfunction

    // First phy lane whose ID is out of range or repeats an earlier one; -1 if a valid permutation.
    function automatic int first_bad(input ids_t id, input int n);
        bit seen [32];
        seen = '{default: 1'b0};
        for (int p = 0; p < n; p++) begin
            if (id[p] >= n || seen[id[p]]) return p;
            seen[id[p]] = 1'b1;
        end
        return -1;
    endfunction

    function automatic ids_t rand_perm(input int n);
        ids_t r;
        int j, t;
        r = '{default: 0};
        for (int p = 0; p < n; p++) r[p] = p;
        for (int i = n - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = r[i]; r[i] = r[j]; r[j] = t;
        end
        return r;
    endfunction

    function automatic ids_t mk4(input int a, input int b, input int c, input int d);
        ids_t r;
        r = '{default: 0};
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Force COLLECT via restart, then present the IDs with full lock.
    task automatic start(input bit big, input ids_t id);
        logic [NB*WB-1:0] bus;
        bus = pack_bus(id, big ? NB : NA, big ? WB : WA);
        if (big) begin
            b_en = 0; b_lock = '0; b_ids = bus; b_rs = 1;
        end else begin
            a_en = 0; a_lock = '0; a_ids = bus[NA*WA-1:0]; a_rs = 1;
        end
        tick();
        if (big) begin b_rs = 0; b_lock = '1; end
        else     begin a_rs = 0; a_lock = '1; end
    endtask

    // Count edges from the one that samples full lock (edge 1) to done or error.
    task automatic acquire(input bit big, input ids_t id, output int done_at, output int err_at, output int el);
        done_at = -1; err_at = -1; el = -1;
        start(big, id);
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (big ? b_done : a_done) begin done_at = c; break; end
            if (big ? b_er : a_er) begin err_at = c; el = big ? int'(b_el) : int'(a_el); break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0;
        a_en = 0; a_rs = 0; a_lock = '0; a_ids = '0;
        b_en = 0; b_rs = 0; b_lock = '0; b_ids = '0;
        tick(); tick();
        vectors++;
        if ({a_sel, a_done, a_load, a_shift, a_al, a_er, a_el} !== '0) begin
            miscompares++; $display("FAIL reset_a: got sel=%h done=%b load=%b shift=%b al=%b er=%b el=%0d, want all 0",
                a_sel, a_done, a_load, a_shift, a_al, a_er, a_el);
        end
        vectors++;
        if ({b_sel, b_done, b_load, b_shift, b_al, b_er, b_el} !== '0) begin
            miscompares++; $display("FAIL reset_b: got sel=%h done=%b load=%b shift=%b al=%b er=%b el=%0d, want all 0",
                b_sel, b_done, b_load, b_shift, b_al, b_er, b_el);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_identity();
        ids_t id;
        int d, e, l;
        logic [NB*WB-1:0] ex;
        id = mk4(0, 1, 2, 3);
        acquire(0, id, d, e, l);
        vectors++;
        if (d !== NA + 1) begin miscompares++; $display("FAIL identity_latency: got %0d want %0d", d, NA + 1); end
        ex = exp_sel(id, NA, WA);
        vectors++;
        if (a_sel !== ex[NA*WA-1:0]) begin miscompares++; $display("FAIL identity_sel: got %h want %h", a_sel, ex[NA*WA-1:0]); end
        tick();
        vectors++;
        if ({a_al, a_done, a_load, a_shift} !== 4'b1000) begin
            miscompares++; $display("FAIL identity_run: got al/done/load/shift=%b want 1000", {a_al, a_done, a_load, a_shift});
        end
    endtask

    task automatic test_permutation();
        ids_t id;
        int d, e, l;
        logic [NB*WB-1:0] ex;
        logic [1:0] want;
        for (int r = 0; r < 4; r++) begin
            id = (r == 0) ? mk4(2, 0, 3, 1) : rand_perm(NA);
            acquire(0, id, d, e, l);
            vectors++;
            if (d !== NA + 1) begin miscompares++; $display("FAIL perm_latency: got %0d want %0d", d, NA + 1); end
            ex = exp_sel(id, NA, WA);
            vectors++;
            if (a_sel !== ex[NA*WA-1:0]) begin miscompares++; $display("FAIL perm_sel: got %h want %h", a_sel, ex[NA*WA-1:0]); end
            a_en = 1;
            tick();
            for (int k = 1; k <= 2 * NA; k++) begin
                tick();
                want = (k % NA == 0) ? 2'b10 : 2'b01;
                vectors++;
                if ({a_load, a_shift} !== want) begin
                    miscompares++; $display("FAIL perm_pace step %0d: got load/shift=%b want %b", k, {a_load, a_shift}, want);
                end
            end
            a_en = 0;
        end
    endtask

    task automatic test_duplicate();
        ids_t id;
        int d, e, l, bad;
        for (int r = 0; r < 5; r++) begin
            if (r == 0) id = mk4(1, 1, 2, 3);
            else begin
                do id = mk4($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0));
                while (first_bad(id, NA) < 0);
            end
            bad = first_bad(id, NA);
            acquire(0, id, d, e, l);
            vectors++;
            if (e !== bad + 2 || l !== bad || d !== -1) begin
                miscompares++; $display("FAIL dup_error: got err_at=%0d lane=%0d done_at=%0d want err_at=%0d lane=%0d done_at=-1",
                    e, l, d, bad + 2, bad);
            end
            for (int k = 0; k < 3; k++) begin
                tick();
                vectors++;
                if ({a_er, a_done, a_al} !== 3'b100) begin
                    miscompares++; $display("FAIL dup_hold: got er/done/al=%b want 100", {a_er, a_done, a_al});
                end
            end
            a_rs = 1;
            tick();
            a_rs = 0;
            vectors++;
            if ({a_er, a_al} !== 2'b00) begin miscompares++; $display("FAIL dup_restart: got er/al=%b want 00", {a_er, a_al}); end
        end
    endtask

    task automatic test_lock_loss();
        ids_t id;
        int d, e, l, c;
        logic [NB*WB-1:0] ex;
        id = rand_perm(NA);
        acquire(0, id, d, e, l);
        a_en = 1;
        tick(); tick(); tick();
        a_lock = 4'b1011;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if ({a_al, a_load, a_shift, a_done} !== 4'b0000) begin
                miscompares++; $display("FAIL lockloss_run: got al/load/shift/done=%b want 0000", {a_al, a_load, a_shift, a_done});
            end
        end
        a_en = 0;
        a_lock = '1;
        d = -1;
        for (c = 1; c <= 40; c++) begin
            tick();
            if (a_done) begin d = c; break; end
        end
        vectors++;
        if (d !== NA + 1) begin miscompares++; $display("FAIL lockloss_relock: got done_at=%0d want %0d", d, NA + 1); end
        ex = exp_sel(id, NA, WA);
        vectors++;
        if (a_sel !== ex[NA*WA-1:0]) begin miscompares++; $display("FAIL lockloss_sel: got %h want %h", a_sel, ex[NA*WA-1:0]); end

        // Lock drops on the very edge that would have entered ERROR.
        start(0, mk4(1, 1, 2, 3));
        tick(); tick();
        a_lock = 4'b1110;
        tick();
        vectors++;
        if ({a_er, a_al} !== 2'b00) begin miscompares++; $display("FAIL lockloss_vs_error: got er/al=%b want 00", {a_er, a_al}); end

        // Lock drops on the very edge that would have entered DONE.
        start(0, id);
        for (int k = 0; k < NA; k++) tick();
        a_lock = 4'b0111;
        tick();
        vectors++;
        if ({a_done, a_al, a_er} !== 3'b000) begin
            miscompares++; $display("FAIL lockloss_vs_done: got done/al/er=%b want 000", {a_done, a_al, a_er});
        end

        // Lock-loss also leaves ERROR.
        acquire(0, mk4(3, 3, 0, 1), d, e, l);
        a_lock = 4'b1101;
        tick();
        vectors++;
        if (a_er !== 1'b0 || e !== 3) begin
            miscompares++; $display("FAIL lockloss_from_error: got er=%b err_at=%0d want er=0 err_at=3", a_er, e);
        end
        a_lock = '0;
    endtask

    task automatic test_stall();
        ids_t id;
        int d, e, l, ecnt;
        bit en;
        bit pat [6] = '{1, 0, 1, 1, 0, 1};
        logic [1:0] want;
        id = rand_perm(NA);
        acquire(0, id, d, e, l);
        a_en = 0;
        tick();
        ecnt = 0;
        for (int i = 0; i < 24; i++) begin
            en = (i < 6) ? pat[i] : 1'($urandom_range(1, 0));
            a_en = en;
            tick();
            if (en) ecnt++;
            want = !en ? 2'b00 : ((ecnt % NA == 0) ? 2'b10 : 2'b01);
            vectors++;
            if ({a_load, a_shift} !== want) begin
                miscompares++; $display("FAIL stall cycle %0d en=%0d: got load/shift=%b want %b", i, en, {a_load, a_shift}, want);
            end
        end
        a_en = 0;
    endtask

    task automatic test_reset_mid_build();
        start(0, rand_perm(NA));
        tick(); tick();
        rst_n = 0;
        tick();
        vectors++;
        if ({a_sel, a_done, a_load, a_shift, a_al, a_er, a_el} !== '0) begin
            miscompares++; $display("FAIL reset_mid_build: got sel=%h done=%b al=%b er=%b want all 0", a_sel, a_done, a_al, a_er);
        end
        rst_n = 1;
        a_lock = '0;
        tick();
    endtask

    task automatic test_default20();
        ids_t id;
        int d, e, l, bad, j, k;
        logic [1:0] want;
        for (int r = 0; r < 6; r++) begin
            id = rand_perm(NB);
            if (r == 3) id[$urandom_range(NB - 1, 0)] = $urandom_range(31, NB);
            if (r == 4) begin
                j = $urandom_range(NB - 1, 0);
                do k = $urandom_range(NB - 1, 0); while (k == j);
                id[k] = id[j];
            end
            bad = first_bad(id, NB);
            acquire(1, id, d, e, l);
            if (bad < 0) begin
                vectors++;
                if (d !== NB + 1) begin miscompares++; $display("FAIL n20_latency: got %0d want %0d", d, NB + 1); end
                vectors++;
                if (b_sel !== exp_sel(id, NB, WB)) begin
                    miscompares++; $display("FAIL n20_sel: got %h want %h", b_sel, exp_sel(id, NB, WB));
                end
                b_en = 1;
                tick();
                for (int s = 1; s <= 2 * NB; s++) begin
                    tick();
                    want = (s % NB == 0) ? 2'b10 : 2'b01;
                    vectors++;
                    if ({b_load, b_shift} !== want) begin
                        miscompares++; $display("FAIL n20_pace step %0d: got load/shift=%b want %b", s, {b_load, b_shift}, want);
                    end
                end
                b_en = 0;
            end else begin
                vectors++;
                if (e !== bad + 2 || l !== bad || d !== -1) begin
                    miscompares++; $display("FAIL n20_error: got err_at=%0d lane=%0d done_at=%0d want err_at=%0d lane=%0d",
                        e, l, d, bad + 2, bad);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_permutation();
        test_duplicate();
        test_lock_loss();
        test_stall();
        test_reset_mid_build();
        test_default20();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
